// File: rtl/a2d_spi_resp.sv
// a2d_spi_resp: converter-side SPI responder for the two-word A2D frame.
// Receives the channel command, then returns the complemented 12-bit sample.
module a2d_spi_resp (
   input  logic        clk,
   input  logic        rst,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   output logic [2:0]  chnnl,
   input  logic [11:0] smpl,
   output logic        cmd_vld,
   output logic        frm_done,
   output logic        frm_err
);
   typedef enum logic [1:0] {IDLE, CMD, RESP, DONE} state_t;
   state_t      state_q, state_d;
   logic [2:0]  ss_sync_q, ss_sync_d, sclk_sync_q, sclk_sync_d;
   logic [1:0]  mosi_sync_q, mosi_sync_d;
   logic [15:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d, rx_next;
   logic [5:0]  bit_cnt_q, bit_cnt_d;
   logic [2:0]  chnnl_q, chnnl_d;
   logic        cmd_vld_q, cmd_vld_d, frm_done_q, frm_done_d, frm_err_q, frm_err_d;
   logic        sclk_rise, sclk_fall, ss_fall, ss_rise;

   assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
   assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
   assign ss_rise   = ss_sync_q[1] & ~ss_sync_q[2];
   assign ss_fall   = ~ss_sync_q[1] & ss_sync_q[2];
   assign rx_next   = {rx_shift_q[14:0], mosi_sync_q[1]};

   always_comb begin
      ss_sync_d   = {ss_sync_q[1:0], SS_n};
      sclk_sync_d = {sclk_sync_q[1:0], SCLK};
      mosi_sync_d = {mosi_sync_q[0], MOSI};
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_shift_d  = rx_shift_q;
      tx_shift_d  = tx_shift_q;
      chnnl_d     = chnnl_q;
      cmd_vld_d   = 1'b0;
      frm_done_d  = 1'b0;
      frm_err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            bit_cnt_d = 6'd0;
            if (ss_fall) state_d = CMD;
         end
         CMD: begin
            if (ss_rise) begin
               frm_err_d = 1'b1;
               state_d   = IDLE;
               bit_cnt_d = 6'd0;
            end else if (sclk_rise) begin
               rx_shift_d = rx_next;
               bit_cnt_d  = bit_cnt_q + 6'd1;
               if (bit_cnt_q == 6'd15) begin
                  chnnl_d   = rx_next[13:11];
                  cmd_vld_d = 1'b1;
                  state_d   = RESP;
               end
            end
         end
         RESP: begin
            if (ss_rise) begin
               frm_err_d = 1'b1;
               state_d   = IDLE;
               bit_cnt_d = 6'd0;
            end else begin
               // sample source has had one clk to follow the newly latched chnnl
               tx_shift_d = cmd_vld_q ? {4'b0000, ~smpl} : sclk_fall ? {tx_shift_q[14:0], 1'b0} : tx_shift_q;
               if (sclk_rise) begin
                  bit_cnt_d = bit_cnt_q + 6'd1;
                  if (bit_cnt_q == 6'd31) state_d = DONE;
               end
            end
         end
         default: begin
            if (ss_rise) begin
               frm_done_d = 1'b1;
               state_d    = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ss_sync_q   <= 3'b111;
         sclk_sync_q <= 3'b111;
         mosi_sync_q <= 2'b00;
         rx_shift_q  <= 16'h0000;
         tx_shift_q  <= 16'h0000;
         bit_cnt_q   <= 6'd0;
         chnnl_q     <= 3'd0;
         cmd_vld_q   <= 1'b0;
         frm_done_q  <= 1'b0;
         frm_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ss_sync_q   <= ss_sync_d;
         sclk_sync_q <= sclk_sync_d;
         mosi_sync_q <= mosi_sync_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         bit_cnt_q   <= bit_cnt_d;
         chnnl_q     <= chnnl_d;
         cmd_vld_q   <= cmd_vld_d;
         frm_done_q  <= frm_done_d;
         frm_err_q   <= frm_err_d;
      end
   end

   assign MISO     = (state_q == RESP) ? tx_shift_q[15] : (state_q == DONE) ? 1'b0 : 1'b1;
   assign chnnl    = chnnl_q;
   assign cmd_vld  = cmd_vld_q;
   assign frm_done = frm_done_q;
   assign frm_err  = frm_err_q;
endmodule
